ber_test_sequencer: RTL and testbench

Controller that sequences one bit-error-rate measurement around the PRBS generator and its downstream checker. It latches a test configuration on `start`, holds the generator and checker in reset, and waits for checker lock. It then counts a programmed number of bits and the errors among them, and reports counts plus a completion status. It sits between the control/register block and the PRBS generator/checker pair, all on the single 100 MHz domain.

---
 rtl/ber_test_sequencer.sv | 154 +++++++++++++++
 tb/tb_ber_test_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_test_sequencer.sv
// BER test sequencer: resets the PRBS generator/checker, waits for checker lock,
// then counts bits and errors. Define BER_SEQ_TIMEOUT_EN to bound the lock wait.
module ber_test_sequencer #(
    parameter int CNT_W        = 32,
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      cfg_error_rate,
    input  logic [CNT_W-1:0] cfg_test_len,
    input  logic             chk_lock,
    input  logic             chk_err,
    output logic             prbs_rst,
    output logic [15:0]      prbs_error_rate,
    output logic             chk_rst,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       dbg_state
);

    // Handshake: start is a level sampled only in IDLE; done is a one-cycle
    // pulse in DONE, and results stay valid until the next accepted start.

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_LOST    = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_param
        $error("ber_test_sequencer: RST_CYCLES and LOCK_TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_SYNC  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [RC_W-1:0]  rst_cnt;
    logic [CNT_W-1:0] bit_inc;
    logic [CNT_W-1:0] err_inc;

`ifdef BER_SEQ_TIMEOUT_EN
    localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    logic [TO_W-1:0] sync_cnt;
`endif

    // Saturating increments: the counters stick at all-ones rather than wrap.
    always_comb begin
        bit_inc = (bit_count == '1) ? bit_count : bit_count + CNT_W'(1);
        err_inc = (err_count == '1) ? err_count : err_count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            len_q           <= '0;
            prbs_error_rate <= 16'hFFFF;
            status          <= ST_OK;
            bit_count       <= '0;
            err_count       <= '0;
            rst_cnt         <= '0;
`ifdef BER_SEQ_TIMEOUT_EN
            sync_cnt        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state           <= S_RESET;
                        len_q           <= cfg_test_len;
                        prbs_error_rate <= cfg_error_rate;
                        status          <= ST_OK;
                        bit_count       <= '0;
                        err_count       <= '0;
                        rst_cnt         <= '0;
                    end
                end
                S_RESET: begin
                    if (abort) begin
                        state  <= S_DONE;
                        status <= ST_ABORT;
                    end else if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        state <= S_SYNC;
`ifdef BER_SEQ_TIMEOUT_EN
                        sync_cnt <= '0;
`endif
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                S_SYNC: begin
                    if (abort) begin
                        state  <= S_DONE;
                        status <= ST_ABORT;
                    end else if (chk_lock) begin
                        // A zero-length test completes on lock without counting.
                        state <= (len_q == '0) ? S_DONE : S_RUN;
`ifdef BER_SEQ_TIMEOUT_EN
                    end else if (sync_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                        state  <= S_DONE;
                        status <= ST_TIMEOUT;
                    end else begin
                        sync_cnt <= sync_cnt + TO_W'(1);
`endif
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state  <= S_DONE;
                        status <= ST_ABORT;
                    end else if (!chk_lock) begin
                        state  <= S_DONE;
                        status <= ST_LOST;
                    end else begin
                        bit_count <= bit_inc;
                        if (chk_err) begin
                            err_count <= err_inc;
                        end
                        if (bit_inc == len_q) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Control outputs decode straight from the state register.
    assign prbs_rst  = (state == S_IDLE) || (state == S_RESET) || (state == S_DONE);
    assign chk_rst   = prbs_rst;
    assign busy      = (state == S_RESET) || (state == S_SYNC) || (state == S_RUN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Bench for ber_test_sequencer: random and directed tests, results checked
// against a closed-form model through an expected-result queue.
module tb_ber_test_sequencer;

    localparam int CW = 8;
    localparam int RC = 4;
    localparam int LT = 1024;
    localparam int EW = 2 + 2 * CW + 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [15:0]   cfg_error_rate;
    logic [CW-1:0] cfg_test_len;
    logic          chk_lock;
    logic          chk_err;
    logic          prbs_rst;
    logic [15:0]   prbs_error_rate;
    logic          chk_rst;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [CW-1:0] bit_count;
    logic [CW-1:0] err_count;
    logic [2:0]    dbg_state;

    ber_test_sequencer #(.CNT_W(CW), .RST_CYCLES(RC), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_error_rate(cfg_error_rate), .cfg_test_len(cfg_test_len),
        .chk_lock(chk_lock), .chk_err(chk_err),
        .prbs_rst(prbs_rst), .prbs_error_rate(prbs_error_rate), .chk_rst(chk_rst),
        .busy(busy), .done(done), .status(status),
        .bit_count(bit_count), .err_count(err_count), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;
    bit            err_pat[256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result from the test rules: the run ends at the first of
    // abort, lock loss or the last bit; abort wins ties, then lock loss.
    function automatic logic [EW-1:0] model(input int len, input int drop_at,
                                            input int abort_at, input logic [15:0] er);
        int         inf = 1 << 30;
        int         a   = (abort_at < 0) ? inf : abort_at;
        int         d   = (drop_at < 0) ? inf : drop_at;
        int         bits;
        int         errs = 0;
        logic [1:0] st;
        if (len == 0) begin
            bits = 0;
            st   = 2'd0;
        end else begin
            bits = len;
            if (a < bits) bits = a;
            if (d < bits) bits = d;
            if (a <= len - 1 && a <= d) st = 2'd3;
            else if (d <= len - 1)      st = 2'd2;
            else                        st = 2'd0;
        end
        for (int i = 0; i < bits; i++) errs += int'(err_pat[i]);
        return {st, CW'(bits), CW'(errs), er};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic          done_prev = 1'b0;
    logic [EW-1:0] mon_e;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_single_cycle", {63'd0, done_prev}, 64'd0);
            check("busy_low_at_done", {63'd0, busy}, 64'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: status %0d bits %0d errs %0d", status, bit_count, err_count);
            end else begin
                mon_e = exp_q.pop_front();
                check("result{status,bits,errs,rate}",
                      64'({status, bit_count, err_count, prbs_error_rate}), 64'(mon_e));
            end
        end
        done_prev <= done;
    end

    // ---------------- driver tasks ----------------
    task automatic issue_start(input int len, input logic [15:0] er);
        int n = 0;
        @(negedge clk);
        cfg_test_len   = CW'(len);
        cfg_error_rate = er;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        while (prbs_rst && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("prbs_rst_cycles", 64'(n), 64'(RC));
        check("chk_rst_low_in_sync", {63'd0, chk_rst}, 64'd0);
    endtask

    task automatic run_test(input int len, input int lock_delay, input int drop_at,
                            input int abort_at, input bit noise);
        logic [15:0] er = 16'($urandom_range(0, 65535));
        int          i  = 0;
        last_exp = model(len, drop_at, abort_at, er);
        exp_q.push_back(last_exp);
        issue_start(len, er);
        repeat (lock_delay) @(negedge clk);
        chk_lock = 1'b1;
        @(negedge clk);
        while (busy && i < 260) begin
            chk_lock = (i != drop_at);
            chk_err  = (i < 256) ? err_pat[i] : 1'b0;
            abort    = (i == abort_at);
            if (noise && i == 2) begin
                start          = 1'b1;
                cfg_test_len   = CW'($urandom);
                cfg_error_rate = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            i++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout: busy still %0d after %0d cycles", busy, i);
        end
        start    = 1'b0;
        abort    = 1'b0;
        chk_lock = 1'b0;
        chk_err  = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_prbs_rst"}, {63'd0, prbs_rst}, 64'd1);
        check({tag, "_chk_rst"}, {63'd0, chk_rst}, 64'd1);
        check({tag, "_error_rate"}, 64'(prbs_error_rate), 64'hFFFF);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_status"}, 64'(status), 64'd0);
        check({tag, "_bit_count"}, 64'(bit_count), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] er;
        int          n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; chk_lock = 1'b0; chk_err = 1'b0;
        cfg_error_rate = 16'h0; cfg_test_len = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Normal run: an error on every 10th counted bit.
        for (int i = 0; i < 256; i++) err_pat[i] = ((i % 10) == 9);
        run_test(100, 3, -1, -1, 1'b1);

        // Abort while idle must leave the previous results untouched.
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_abort_busy", {63'd0, busy}, 64'd0);
        check("idle_abort_hold", 64'({status, bit_count, err_count}), 64'(last_exp[EW-1:16]));
        abort = 1'b0;

        run_test(100, 2, 50, -1, 1'b0);     // lock lost on the 51st RUN cycle
        run_test(20, 1, -1, 19, 1'b0);      // abort on the final bit
        run_test(20, 0, 7, 7, 1'b0);        // abort and lock loss together

        for (int i = 0; i < 256; i++) err_pat[i] = 1'b1;
        run_test(0, 2, -1, -1, 1'b0);
        run_test(15, 1, -1, -1, 1'b0);
        run_test(255, 0, -1, -1, 1'b0);     // counters reach all-ones

        for (int t = 0; t < 10; t++) begin
            int len = $urandom_range(0, 40);
            int ld  = $urandom_range(0, 6);
            int dr  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 45) : -1;
            int ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 45) : -1;
            for (int i = 0; i < 256; i++) err_pat[i] = 1'($urandom_range(0, 1));
            run_test(len, ld, dr, ab, 1'b1);
        end

        // Reset in the middle of a run.
        issue_start(100, 16'h1234);
        chk_lock = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid_rst");
        rst = 1'b0;
        chk_lock = 1'b0;
        @(negedge clk);

        // Lock never arrives.
        er = 16'($urandom_range(0, 65535));
`ifdef BER_SEQ_TIMEOUT_EN
        exp_q.push_back({2'd1, CW'(0), CW'(0), er});
        issue_start(10, er);
        n = 0;
        while (busy && n < LT + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_sync_cycles", 64'(n), 64'(LT));
`else
        issue_start(10, er);
        repeat (2000) @(negedge clk);
        check("no_timeout_busy", {63'd0, busy}, 64'd1);
        exp_q.push_back({2'd3, CW'(0), CW'(0), er});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n = 0;
        check("abort_in_sync_busy", {63'd0, busy}, 64'd0);
`endif
        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end

endmodule
